// File: rtl/game_pkg.sv
// Shared definitions for the brick-breaker game controller: state encoding
// and default playfield constants.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OVER  = 3'd5
  } state_t;

  localparam int         NUM_BRICKS = 25;
  localparam int         LIVES_INIT = 3;
  localparam logic [9:0] MISS_Y     = 10'd470;
  localparam int         SCREEN_H   = 480;

endpackage

// File: rtl/game_brick_tracker.sv
// Brick wall state: owns the presence mask, qualifies erase strobes and
// flags when the wall is empty.
module brick_tracker
  import game_pkg::*;
#(
  parameter int NUM_BRICKS = game_pkg::NUM_BRICKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_fill,
  input  logic                  i_erase_en,
  input  logic [5:0]            i_e_pos,
  output logic [NUM_BRICKS-1:0] o_mask,
  output logic                  o_hit,
  output logic                  o_hit_last,
  output logic                  o_all_clear
);

  logic [NUM_BRICKS-1:0] r_mask;
  logic [NUM_BRICKS-1:0] w_sel;
  logic                  w_in_range;

  always_comb begin
    w_in_range  = 32'(i_e_pos) < NUM_BRICKS;
    w_sel       = w_in_range ? (NUM_BRICKS'(1) << i_e_pos) : '0;
    o_hit       = i_erase_en & (|(r_mask & w_sel));
    // hit that removes the only remaining brick
    o_hit_last  = o_hit & ~(|(r_mask & ~w_sel));
    o_all_clear = ~(|r_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask <= '1;
    end else if (i_fill) begin
      r_mask <= '1;
    end else if (o_hit) begin
      r_mask <= r_mask & ~w_sel;
    end
  end

  assign o_mask = r_mask;

endmodule

// File: rtl/game_ctrl.sv
// Game controller FSM: serve/play/miss/clear/over sequencing, lives and score.
// Optional AUTO_SERVE_EN: SERVE also proceeds to PLAY after SERVE_WAIT frames.
module game_ctrl
  import game_pkg::*;
#(
  parameter int         NUM_BRICKS = game_pkg::NUM_BRICKS,
  parameter int         LIVES_INIT = game_pkg::LIVES_INIT,
  parameter logic [9:0] MISS_Y     = game_pkg::MISS_Y,
  parameter int         SERVE_WAIT = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  launch,
  input  logic                  erase_enable,
  input  logic [5:0]            e_pos,
  input  logic [9:0]            ball_y,
  output logic                  ball_reset,
  output logic                  ball_step,
  output logic [NUM_BRICKS-1:0] brick_mask,
  output logic [1:0]            lives,
  output logic [9:0]            score,
  output logic [2:0]            state,
  output logic                  game_over
);

  localparam int CW = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_WAIT - 1);

  state_t          r_state;
  logic            r_ball_reset;
  logic            r_game_over;
  logic [1:0]      r_lives;
  logic [9:0]      r_score;
  logic [CW-1:0]   r_clear_cnt;
`ifdef AUTO_SERVE_EN
  logic [CW-1:0]   r_serve_cnt;
`endif

  logic w_init;
  logic w_refill;
  logic w_fill;
  logic w_erase_en;
  logic w_hit;
  logic w_hit_last;
  logic w_all_clear;
  logic w_miss;

  always_comb begin
    w_init     = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && launch;
    w_refill   = (r_state == ST_CLEAR) && frame_tick && (r_clear_cnt == CNT_LAST);
    w_fill     = w_init || w_refill;
    w_erase_en = erase_enable && (r_state == ST_PLAY);
    w_miss     = frame_tick && (ball_y >= MISS_Y);
  end

  brick_tracker #(
    .NUM_BRICKS(NUM_BRICKS)
  ) u_bricks (
    .clk        (clk),
    .reset      (reset),
    .i_fill     (w_fill),
    .i_erase_en (w_erase_en),
    .i_e_pos    (e_pos),
    .o_mask     (brick_mask),
    .o_hit      (w_hit),
    .o_hit_last (w_hit_last),
    .o_all_clear(w_all_clear)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ball_reset <= 1'b1;
      r_game_over  <= 1'b0;
      r_lives      <= 2'(LIVES_INIT);
      r_score      <= '0;
      r_clear_cnt  <= '0;
`ifdef AUTO_SERVE_EN
      r_serve_cnt  <= '0;
`endif
    end else begin
      if (w_hit && (r_score != '1)) begin
        r_score <= r_score + 10'd1;
      end
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (launch) begin
            r_state      <= ST_SERVE;
            r_ball_reset <= 1'b1;
            r_game_over  <= 1'b0;
            r_lives      <= 2'(LIVES_INIT);
            r_score      <= '0;
          end
        end
        ST_SERVE: begin
`ifdef AUTO_SERVE_EN
          if (launch || (frame_tick && (r_serve_cnt == CNT_LAST))) begin
            r_state      <= ST_PLAY;
            r_ball_reset <= 1'b0;
            r_serve_cnt  <= '0;
          end else if (frame_tick) begin
            r_serve_cnt  <= r_serve_cnt + CW'(1);
          end
`else
          if (launch) begin
            r_state      <= ST_PLAY;
            r_ball_reset <= 1'b0;
          end
`endif
        end
        ST_PLAY: begin
          // an erase that empties the wall this cycle outranks a coincident miss
          if (w_all_clear) begin
            r_state      <= ST_CLEAR;
            r_ball_reset <= 1'b1;
          end else if (w_miss && !w_hit_last) begin
            r_state      <= ST_MISS;
            r_ball_reset <= 1'b1;
            if (r_lives != 2'd0) begin
              r_lives <= r_lives - 2'd1;
            end
          end
        end
        ST_MISS: begin
          if (r_lives == 2'd0) begin
            r_state     <= ST_OVER;
            r_game_over <= 1'b1;
          end else begin
            r_state     <= ST_SERVE;
          end
        end
        ST_CLEAR: begin
          if (frame_tick) begin
            if (r_clear_cnt == CNT_LAST) begin
              r_clear_cnt <= '0;
              r_state     <= ST_SERVE;
            end else begin
              r_clear_cnt <= r_clear_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_ball_reset <= 1'b1;
          r_game_over  <= 1'b0;
        end
      endcase
    end
  end

  assign ball_step  = (r_state == ST_PLAY) && frame_tick;
  assign ball_reset = r_ball_reset;
  assign game_over  = r_game_over;
  assign lives      = r_lives;
  assign score      = r_score;
  assign state      = r_state;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
  NUM_BRICKS, 25, brick count, one mask bit per brick
  LIVES_INIT, 3, lives at game start
  MISS_Y, 10'd470, ball_y at or beyond this value is a miss
  SERVE_WAIT, 60, frame_ticks spent in CLEAR before the next serve
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
  clk  in  1  game clock
  reset  in  1  asynchronous, active-high reset
  frame_tick  in  1  one-cycle pulse per video frame
  launch  in  1  player button, level-sensitive
  erase_enable  in  1  brick-hit strobe from the ball datapath
  e_pos  in  6  index of the brick hit
  ball_y  in  10  current ball row
  ball_reset  out  1  holds the ball datapath at its serve position
  ball_step  out  1  one-cycle enable that advances the ball by one move
  brick_mask  out  NUM_BRICKS  1 = brick present
  lives  out  2  remaining lives
  score  out  10  bricks destroyed, saturating
  state  out  3  current controller state
  game_over  out  1  high while in OVER

Function
REQ-003 The FSM SHALL have states IDLE, SERVE, PLAY, MISS, CLEAR and OVER; all transitions are registered.
REQ-004 IDLE -> SERVE on launch, same edge: brick_mask all ones, lives=LIVES_INIT, score=0.
REQ-005 SERVE -> PLAY on launch (see REQ-017).
REQ-006 PLAY: ball_step=frame_tick and ball_reset=0; in every other state ball_step=0 and ball_reset=1.
REQ-007 erase_enable with e_pos<NUM_BRICKS and brick_mask[e_pos]=1 (PLAY only) SHALL clear that bit and increment score, saturating at 1023.
REQ-008 erase_enable on an already-cleared bit, with e_pos>=NUM_BRICKS, or outside PLAY SHALL be ignored: no mask or score change.
REQ-009 PLAY -> CLEAR on the edge after brick_mask becomes all zeros; CLEAR takes priority over a same-cycle miss.
REQ-010 PLAY, frame_tick=1 and ball_y>=MISS_Y -> MISS, with lives decremented on the same edge.
REQ-011 MISS lasts exactly one cycle: next state OVER if lives==0, else SERVE.
REQ-012 CLEAR SHALL count SERVE_WAIT frame_ticks, then refill brick_mask to all ones and go to SERVE; lives and score are preserved.
REQ-013 OVER: game_over=1; launch -> SERVE with the same initialisation as REQ-004.
REQ-014 If erase_enable and a miss occur in the same cycle, the erase SHALL be counted before the miss is taken.

Reset
REQ-015 Asserting reset at any time SHALL force all of the following, including mid-game:
  state=IDLE, ball_reset=1, ball_step=0
  brick_mask all ones, lives=LIVES_INIT, score=0
  game_over=0, CLEAR counter=0
REQ-016 The block SHALL leave reset synchronously to clk on the first edge after reset deasserts.

Configuration
REQ-017 With AUTO_SERVE_EN defined, SERVE SHALL also go to PLAY after SERVE_WAIT frame_ticks without launch.
REQ-018 Without AUTO_SERVE_EN, SERVE SHALL wait only for launch and contain no serve counter.

Structure
REQ-019 A shared package game_pkg SHALL hold:
  the state encoding (IDLE=0, SERVE=1, PLAY=2, MISS=3, CLEAR=4, OVER=5)
  NUM_BRICKS, LIVES_INIT, MISS_Y and SCREEN_H
REQ-020 Sub-module brick_tracker SHALL own brick_mask, the valid-erase qualification and the all-cleared flag; game_ctrl instantiates it once.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
  Reset, then launch twice -> state IDLE->SERVE->PLAY; ball_step pulses once per frame_tick; lives=3, score=0.
  erase e_pos=5 twice, then e_pos=30 -> brick_mask[5]=0; score=1 after all three.
  All 25 bricks erased -> CLEAR; after 60 frame_ticks -> SERVE, mask=all ones, score=25 held.
  ball_y=470 on frame_tick with lives=1 -> MISS, lives=0 -> OVER, game_over=1; launch -> SERVE, lives=3.
  Last brick erase and miss in the same cycle -> CLEAR entered; lives unchanged.
  reset asserted mid-PLAY -> state IDLE and score=0 immediately, without waiting for a clk edge.
